// File: rtl/aes_round_sequencer_if.sv
// ----------------------------------------------------------------------------
// aes_round_sequencer_if
//   Bundles the block handshake, key-expansion handshake and datapath control
//   signals of the AES round sequencer.
//   master : block producer / key expansion / consumer side (drives requests).
//   slave  : the sequencer itself (drives ready, round index and selects).
// ----------------------------------------------------------------------------
interface aes_round_sequencer_if #(
    parameter int RND_BITS = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          key_len;
    logic                abort;
    logic                rk_valid;
    logic                rk_req;
    logic [RND_BITS-1:0] round_num;
    logic                round_en;
    logic                sel_init;
    logic                sel_final;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    modport master (
        output in_valid, key_len, abort, rk_valid, out_ready,
        input  in_ready, rk_req, round_num, round_en, sel_init, sel_final,
               out_valid, busy
    );

    modport slave (
        input  in_valid, key_len, abort, rk_valid, out_ready,
        output in_ready, rk_req, round_num, round_en, sel_init, sel_final,
               out_valid, busy
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// ----------------------------------------------------------------------------
// aes_round_sequencer
//   Steps an AES cipher datapath through round 0 (AddRoundKey), rounds
//   1..Nr-1 and the final round Nr, stalling whenever key expansion has no
//   round key ready, then holds the ciphertext valid until it is accepted.
//
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : aes_round_sequencer_if.slave
//            in_valid/in_ready/key_len   block request handshake
//            abort                       synchronous cancel
//            rk_valid/rk_req             round-key handshake with key expansion
//            round_num/round_en          round index and state-register enable
//            sel_init/sel_final          round-type selects
//            out_valid/out_ready         ciphertext handshake
//            busy                        not idle
// ----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int RND_BITS = 4,
    parameter int NR_128   = 10,
    parameter int NR_192   = 12,
    parameter int NR_256   = 14
) (
    input logic                  clk,
    input logic                  rst,
    aes_round_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [RND_BITS-1:0] round_q, round_d;
    logic [RND_BITS-1:0] nr_q,    nr_d;

    // Key length 2'b11 is not a legal AES size; it falls back to 128-bit.
    function automatic logic [RND_BITS-1:0] nr_of(input logic [1:0] kl);
        case (kl)
            2'b01:   nr_of = RND_BITS'(NR_192);
            2'b10:   nr_of = RND_BITS'(NR_256);
            default: nr_of = RND_BITS'(NR_128);
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            nr_q    <= RND_BITS'(NR_128);
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        nr_d          = nr_q;
        bus.in_ready  = 1'b0;
        bus.rk_req    = 1'b0;
        bus.round_en  = 1'b0;
        bus.sel_init  = 1'b0;
        bus.sel_final = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    nr_d    = nr_of(bus.key_len);
                    round_d = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                bus.rk_req   = 1'b1;
                bus.sel_init = 1'b1;
                bus.round_en = bus.rk_valid;
                if (bus.rk_valid) begin
                    round_d = RND_BITS'(1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                bus.rk_req   = 1'b1;
                bus.round_en = bus.rk_valid;
                if (bus.rk_valid) begin
                    // Load nr_q directly on the last middle round so the index
                    // can never run past the final round.
                    if (round_q == nr_q - RND_BITS'(1)) begin
                        round_d = nr_q;
                        state_d = FINAL;
                    end else begin
                        round_d = round_q + RND_BITS'(1);
                    end
                end
            end
            FINAL: begin
                bus.rk_req    = 1'b1;
                bus.sel_final = 1'b1;
                bus.round_en  = bus.rk_valid;
                if (bus.rk_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    round_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase

        // Cancel wins over every transition once a block is in flight; in
        // IDLE it is ignored so a same-cycle request is still taken.
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            round_d = '0;
        end
    end

    assign bus.round_num = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ----------------------------------------------------------------------------
// tb_aes_round_sequencer
//   Scoreboard bench: each block request pushes its expected round count and
//   latency; a negedge monitor tracks round_en/selects and pops/compares when
//   out_valid rises.
// ----------------------------------------------------------------------------
module tb_aes_round_sequencer;

    logic clk;
    logic rst;

    aes_round_sequencer_if #(.RND_BITS(4)) bus ();

    aes_round_sequencer #(
        .RND_BITS(4), .NR_128(10), .NR_192(12), .NR_256(14)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int nr;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit active = 0;
        bit seen   = 0;
        int start  = 0;
        int idx    = 0;
        int en_cnt = 0;
        int err    = 0;
        int cur_nr = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
            end else if (!active) begin
                if (bus.in_valid && bus.in_ready) begin
                    active = 1;
                    seen   = 0;
                    start  = cyc;
                    idx    = 0;
                    en_cnt = 0;
                    err    = 0;
                    cur_nr = (sb.size() > 0) ? sb[0].nr : 0;
                end
            end else if (bus.abort && bus.busy) begin
                active = 0;
            end else begin
                if (bus.round_en) begin
                    if (int'(bus.round_num) != idx) err++;
                    if (!bus.rk_valid) err++;
                    idx++;
                    en_cnt++;
                end
                if (bus.sel_init  && bus.round_num != 0) err++;
                if (bus.sel_final && int'(bus.round_num) != cur_nr) err++;
                if (int'(bus.round_num) > cur_nr) err++;
                if (bus.out_valid && !seen) begin
                    seen = 1;
                    if (sb.size() == 0) begin
                        chk("sb_empty", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("latency",    cyc - start,   e.lat);
                        chk("round_done", bus.round_num, e.nr);
                        chk("en_count",   en_cnt,        e.nr + 1);
                        chk("seq_errs",   err,           0);
                    end
                end
                if (bus.out_valid && bus.out_ready) active = 0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    function automatic int nr_for(input logic [1:0] kl);
        return (kl == 2'b10) ? 14 : (kl == 2'b01) ? 12 : 10;
    endfunction

    task automatic run_block(input logic [1:0] kl, input int stall_rnd,
                             input int stall_len, input int hold, input bit abort_acc);
        exp_t e;
        int   left;
        int   c;
        e.nr  = nr_for(kl);
        e.lat = e.nr + 2 + stall_len;
        sb.push_back(e);
        bus.key_len  = kl;
        bus.in_valid = 1'b1;
        bus.abort    = abort_acc;
        bus.rk_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        bus.key_len  = ~kl;    // must be ignored until next accept
        left = stall_len;
        c    = 0;
        while (!bus.out_valid && c < 200) begin
            if (left > 0 && int'(bus.round_num) == stall_rnd && bus.busy) begin
                bus.rk_valid = 1'b0;
                left--;
                #1;
                chk("stall_en",  bus.round_en,  0);
                chk("stall_rnd", bus.round_num, stall_rnd);
            end else begin
                bus.rk_valid = 1'b1;
            end
            step();
            c++;
        end
        if (!bus.out_valid) chk("done_tmo", bus.out_valid, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_ov", bus.out_valid, 1);
            chk("hold_ir", bus.in_ready,  0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("idle_busy", bus.busy,      0);
        chk("idle_rdy",  bus.in_ready,  1);
        chk("idle_rnd",  bus.round_num, 0);
    endtask

    task automatic wait_round(input int r);
        int c = 0;
        while (!(int'(bus.round_num) == r && bus.busy) && c < 100) begin
            step();
            c++;
        end
        chk("wait_rnd", bus.round_num, r);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.key_len   = 2'b00;
        bus.abort     = 1'b0;
        bus.rk_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_ir",  bus.in_ready,  1);
        chk("rst_bsy", bus.busy,      0);
        chk("rst_rnd", bus.round_num, 0);
        chk("rst_ov",  bus.out_valid, 0);
        chk("rst_rkq", bus.rk_req,    0);
        chk("rst_sel", {bus.sel_init, bus.sel_final, bus.round_en}, 0);
        #21 rst = 1'b0;
        step();

        run_block(2'b00, -1, 0, 0, 0);   // 128-bit: 12 cycles
        run_block(2'b10, -1, 0, 0, 0);   // 256-bit: 16 cycles
        run_block(2'b01, -1, 0, 0, 0);   // 192-bit: 14 cycles
        run_block(2'b00,  5, 3, 0, 0);   // 3-cycle stall at round 5: 15 cycles
        run_block(2'b00, -1, 0, 4, 0);   // consumer backpressure in DONE
        run_block(2'b01, -1, 0, 0, 0);   // back-to-back second block
        run_block(2'b11, -1, 0, 0, 0);   // illegal key_len treated as 128
        run_block(2'b10, -1, 0, 0, 1);   // abort in IDLE does not block accept

        // abort mid-block at round 7
        e.nr = 10; e.lat = 12;
        sb.push_back(e);
        bus.key_len = 2'b00; bus.in_valid = 1'b1; bus.rk_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_round(7);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        void'(sb.pop_back());
        chk("abt_busy", bus.busy,      0);
        chk("abt_rnd",  bus.round_num, 0);
        chk("abt_ov",   bus.out_valid, 0);
        chk("abt_ir",   bus.in_ready,  1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abt_no_ov", bus.out_valid, 0);
        end

        // asynchronous reset mid-block (256-bit, round 9)
        e.nr = 14; e.lat = 16;
        sb.push_back(e);
        bus.key_len = 2'b10; bus.in_valid = 1'b1; bus.rk_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.key_len  = 2'b00;
        wait_round(9);
        #2 rst = 1'b1;
        #1;
        void'(sb.pop_back());
        chk("arst_bsy", bus.busy,      0);
        chk("arst_ir",  bus.in_ready,  1);
        chk("arst_rnd", bus.round_num, 0);
        chk("arst_rkq", bus.rk_req,    0);
        chk("arst_ov",  bus.out_valid, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        step();
        run_block(2'b00, -1, 0, 0, 0);   // full 10-round block after reset

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Controls the AES cipher datapath: accepts a block request, steps the round counter from the initial AddRoundKey through the final round, and flags the final output.
- Sits between the block-level input handshake and the round datapath / key-expansion unit.
- Produces the round index and round-type selects, and stalls whenever the key-expansion unit has no round key ready.

Parameters:
- RND_BITS, 4, width of the round index (must hold up to 14).
- NR_128, 10, round count for 128-bit keys.
- NR_192, 12, round count for 192-bit keys.
- NR_256, 14, round count for 256-bit keys.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request to start one block.
- in_ready  out  1  sequencer can accept a request (high only in IDLE).
- key_len  in  2  key length, sampled on accept: 00=128, 01=192, 10=256, 11=treated as 128.
- abort  in  1  synchronous cancel; returns to IDLE next cycle.
- rk_valid  in  1  round key for round_num is available from key expansion.
- rk_req  out  1  round key for round_num is requested.
- round_num  out  RND_BITS  current round index, 0..Nr.
- round_en  out  1  datapath state register updates this cycle.
- sel_init  out  1  round 0 (AddRoundKey only; loads input block).
- sel_final  out  1  round Nr (no MixColumns).
- out_valid  out  1  ciphertext in datapath is valid.
- out_ready  in  1  consumer accepts the ciphertext.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, round_num=0, nr_reg=NR_128. All outputs 0 except in_ready=1.
- States: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch Nr from key_len into nr_reg, set round_num=0, go to INIT next cycle.
- INIT:
  - rk_req=1, sel_init=1.
  - round_en=rk_valid.
  - On rk_valid: round_num←1 and go to ROUND. Otherwise hold.
- ROUND:
  - rk_req=1, round_en=rk_valid.
  - On rk_valid with round_num==nr_reg-1: round_num←nr_reg, go to FINAL.
  - On rk_valid otherwise: round_num←round_num+1.
  - rk_valid=0: hold everything (stall).
- FINAL:
  - rk_req=1, sel_final=1, round_en=rk_valid.
  - On rk_valid: go to DONE.
- DONE:
  - out_valid=1; round_num holds nr_reg.
  - On out_ready: round_num←0, go to IDLE.
  - out_valid is held until accepted and never drops without out_ready.
- round_en, sel_init, sel_final, rk_req and out_valid are decoded from registered state only. They never depend combinationally on in_valid.
- Latency with rk_valid held at 1: accept at cycle 0, INIT at cycle 1, rounds 1..Nr-1 at cycles 2..Nr, FINAL at cycle Nr+1, out_valid at cycle Nr+2.
  - Nr=10: 12 cycles; Nr=12: 14 cycles; Nr=14: 16 cycles.
  - Each rk_valid=0 cycle adds exactly one cycle.
- Back-to-back: DONE with out_ready returns to IDLE, and a new accept is possible the following cycle. Minimum one-cycle gap.
- abort:
  - Priority over all other transitions in every non-IDLE state, including DONE.
  - Next cycle: IDLE, round_num=0, out_valid=0.
  - abort in IDLE has no effect, and an in_valid in the same cycle is still accepted.
- key_len changes after accept are ignored until the next accept.
- Reset asserted mid-operation: immediate return to reset values with no completion pulse.
- round_num never exceeds nr_reg and never wraps.

Test Plan:
- key_len=00, in_valid pulse, rk_valid=1 -> round_num sequence 0,1..10; sel_init only at round 0; sel_final only at round 10; out_valid at cycle 12; 11 round_en pulses.
- key_len=10, rk_valid=1 -> out_valid at cycle 16, round_num=14 in DONE; key_len=01 -> out_valid at cycle 14.
- key_len=00, rk_valid dropped for 3 cycles at round 5 -> round_num holds 5 and round_en=0 during the stall; out_valid at cycle 15.
- out_ready held 0 for 4 cycles in DONE -> out_valid stays 1 and in_ready stays 0; on out_ready=1 -> IDLE next cycle; a second block completes correctly.
- abort at round 7, then rst asserted asynchronously mid-round (key_len=10, round 9) -> abort: IDLE next cycle, no out_valid; rst: outputs immediately at reset values, next accept runs the full 10-round length.
- key_len=11 -> 10 rounds, same as 00.
